// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Source of the vga_if pixel stream. It produces the horizontal and vertical
// counters, the sync and blanking flags, and an optional colour-bar pattern.
// The first draw stage (background) consumes these signals. The default mode
// is 800x600 at 60 Hz, which needs a 40 MHz pixel rate set through pix_en_i.
//
// Ports:
//   clk_i          pixel-domain clock
//   rst_i          synchronous reset, active-high
//   pix_en_i       advance enable (tie high when clk_i runs at 40 MHz)
//   hcount_o[10:0] horizontal pixel position     (vga_if.out hcount)
//   vcount_o[10:0] vertical line position        (vga_if.out vcount)
//   hsync_o        horizontal sync, active-high  (vga_if.out hsync)
//   vsync_o        vertical sync, active-high    (vga_if.out vsync)
//   hblnk_o        horizontal blanking           (vga_if.out hblnk)
//   vblnk_o        vertical blanking             (vga_if.out vblnk)
//   rgb_o[11:0]    pixel colour, 4:4:4           (vga_if.out rgb)
//   frame_start_o  one enabled-cycle pulse when the stream wraps to (0,0)
//   frame_cnt_o    completed-frame counter, wraps modulo 2^16
//
// Optional feature macro: VGA_TIMING_TEST_PATTERN_EN
//   defined   : rgb_o carries eight 100-pixel vertical colour bars, and is
//               black whenever the pixel is blanked
//   undefined : rgb_o is constant zero and the bar logic is not built
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 800,
  parameter int unsigned H_FP      = 40,
  parameter int unsigned H_SYNC    = 128,
  parameter int unsigned H_BP      = 88,
  parameter int unsigned V_VISIBLE = 600,
  parameter int unsigned V_FP      = 1,
  parameter int unsigned V_SYNC    = 4,
  parameter int unsigned V_BP      = 23
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pix_en_i,
  output logic [10:0] hcount_o,
  output logic [10:0] vcount_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        hblnk_o,
  output logic        vblnk_o,
  output logic [11:0] rgb_o,
  output logic        frame_start_o,
  output logic [15:0] frame_cnt_o
);

  localparam int unsigned CNT_W    = 11;
  localparam int unsigned FCNT_W   = 16;
  localparam int unsigned RGB_W    = 12;
  localparam int unsigned CNT_LIM  = 2048;

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_VISIBLE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  // Every timing sum has to fit in the 11-bit counters.
  if (H_TOTAL >= CNT_LIM || V_TOTAL >= CNT_LIM) begin : g_bad_timing
    $error("vga_timing_gen: H_TOTAL=%0d / V_TOTAL=%0d do not fit in 11 bits",
           H_TOTAL, V_TOTAL);
  end

  logic [CNT_W-1:0]  hcount_q, hcount_d;
  logic [CNT_W-1:0]  vcount_q, vcount_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              hblnk_q, hblnk_d;
  logic              vblnk_q, vblnk_d;
  logic              frame_start_q, frame_start_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              h_last;
  logic              v_last;

  // Next pixel position, and flags decoded from that position so that
  // counts and flags leave the register in the same cycle.
  always_comb begin
    h_last        = (hcount_q == CNT_W'(H_TOTAL - 1));
    v_last        = (vcount_q == CNT_W'(V_TOTAL - 1));
    hcount_d      = h_last ? '0 : hcount_q + CNT_W'(1);
    vcount_d      = vcount_q;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;

    if (h_last) begin
      vcount_d = v_last ? '0 : vcount_q + CNT_W'(1);
    end

    if (h_last && v_last) begin
      frame_start_d = 1'b1;
      frame_cnt_d   = frame_cnt_q + FCNT_W'(1);
    end

    hblnk_d = (hcount_d >= CNT_W'(H_VISIBLE));
    hsync_d = (hcount_d >= CNT_W'(HS_START)) && (hcount_d < CNT_W'(HS_END));
    vblnk_d = (vcount_d >= CNT_W'(V_VISIBLE));
    vsync_d = (vcount_d >= CNT_W'(VS_START)) && (vcount_d < CNT_W'(VS_END));
  end

  // Timing registers. Reset overrides pix_en_i. A disabled edge holds every
  // output, which includes a frame_start pulse that is in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else if (pix_en_i) begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

`ifdef VGA_TIMING_TEST_PATTERN_EN
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic [2:0]       bar_idx;

  // Colour bars: 100 pixels per bar, black when the pixel is blanked.
  always_comb begin
    bar_idx = 3'(hcount_d[9:0] / 10'd100);
    rgb_d   = '0;
    if (!(hblnk_d || vblnk_d)) begin
      case (bar_idx)
        3'd0:    rgb_d = 12'hFFF;
        3'd1:    rgb_d = 12'hFF0;
        3'd2:    rgb_d = 12'h0FF;
        3'd3:    rgb_d = 12'h0F0;
        3'd4:    rgb_d = 12'hF0F;
        3'd5:    rgb_d = 12'hF00;
        3'd6:    rgb_d = 12'h00F;
        default: rgb_d = 12'h000;
      endcase
    end
  end

  // The colour is registered in the same stage as the counts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rgb_q <= '0;
    end else if (pix_en_i) begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb_o = rgb_q;
`else
  assign rgb_o = RGB_W'(0);
`endif

  assign hcount_o      = hcount_q;
  assign vcount_o      = vcount_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign hblnk_o       = hblnk_q;
  assign vblnk_o       = vblnk_q;
  assign frame_start_o = frame_start_q;
  assign frame_cnt_o   = frame_cnt_q;

endmodule
